// File: rtl/matmult_result_tx.sv
// Result transmitter for the Strassen 2x2 multiplier.
// Snapshots c11..c22 on start and streams them one word per beat over a
// valid/ready interface, so the multiplier can begin the next product while
// the previous result drains.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame held; out_valid low; waiting for start
// SEND  | frame held in shadow registers; presenting shadow[index] beat
module matmult_result_tx #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] c11_i,
  input  logic [WIDTH-1:0] c12_i,
  input  logic [WIDTH-1:0] c21_i,
  input  logic [WIDTH-1:0] c22_i,
  input  logic             out_ready_i,
  input  logic             clr_overrun_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       out_index_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic [7:0]       frame_count_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       fc_q, fc_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shadow_q [4];

  logic accept;
  logic last_accept;
  logic load;
  logic drop;

  // Next-state logic: beat sequencing, frame counting, capture and drop detection.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fc_d        = fc_q;
    overrun_d   = overrun_q;
    load        = 1'b0;
    drop        = 1'b0;
    accept      = (state_q == SEND) && out_ready_i;
    last_accept = accept && (idx_q == 2'd3);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          idx_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx_q == 2'd3) begin
            fc_d  = fc_q + 8'd1;
            idx_d = 2'd0;
            // A start coinciding with the final accepted beat chains the
            // next frame without a bubble.
            if (start_i) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        if (start_i && !last_accept) begin
          drop = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase

    // A new drop outranks a simultaneous clear so no drop goes unreported.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      fc_q      <= 8'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fc_q      <= fc_d;
      overrun_q <= overrun_d;
    end
  end

  // Shadow registers capture the result words only on an accepted start.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (load) begin
      shadow_q[0] <= c11_i;
      shadow_q[1] <= c12_i;
      shadow_q[2] <= c21_i;
      shadow_q[3] <= c22_i;
    end
  end

  // Outputs come from state and the shadow mux only; c11..c22 never reach out_data.
  always_comb begin
    out_valid_o   = (state_q == SEND);
    busy_o        = (state_q == SEND);
    out_index_o   = idx_q;
    out_last_o    = (state_q == SEND) && (idx_q == 2'd3);
    out_data_o    = (state_q == SEND) ? shadow_q[idx_q] : '0;
    overrun_o     = overrun_q;
    frame_count_o = fc_q;
  end

endmodule

// File: tb/tb_matmult_result_tx.sv
// Self-checking bench for matmult_result_tx: expected beats are queued when a
// start is driven and popped as the bench observes accepted beats.
module tb_matmult_result_tx;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] c11, c12, c21, c22;
  logic        out_ready;
  logic        clr_overrun;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        overrun;
  logic [7:0]  frame_count;

  beat_t       sb[$];
  logic [7:0]  exp_fc;
  int          checks;
  int          failures;

  matmult_result_tx #(.WIDTH(32)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .c11_i         (c11),
    .c12_i         (c12),
    .c21_i         (c21),
    .c22_i         (c22),
    .out_ready_i   (out_ready),
    .clr_overrun_i (clr_overrun),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .out_index_o   (out_index),
    .out_last_o    (out_last),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .frame_count_o (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a frame onto the result inputs and queue its expected beats.
  task automatic push_frame(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    beat_t bt;
    c11 = a; c12 = b; c21 = c; c22 = d;
    bt.data = a; bt.idx = 2'd0; sb.push_back(bt);
    bt.data = b; bt.idx = 2'd1; sb.push_back(bt);
    bt.data = c; bt.idx = 2'd2; sb.push_back(bt);
    bt.data = d; bt.idx = 2'd3; sb.push_back(bt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    c11 = 32'hdead; c12 = 32'hbeef; c21 = 32'h1; c22 = 32'h2;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_index !== 2'd0 ||
        out_last !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || frame_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state v=%0b d=%0d i=%0d l=%0b busy=%0b ovr=%0b fc=%0d want all zero",
               out_valid, out_data, out_index, out_last, busy, overrun, frame_count);
    end
    start = 1'b0;
    rst_n = 1'b1;
    exp_fc = 8'd0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_basic();
    beat_t h;
    out_ready = 1'b1;
    push_frame(32'd1, 32'd2, 32'd3, 32'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      h = sb[0];
      checks++;
      if (out_valid !== 1'b1 || out_data !== h.data || out_index !== 2'(cyc) ||
          out_last !== (cyc == 3) || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_beat cyc=%0d got v=%0b d=%0d i=%0d l=%0b b=%0b want d=%0d i=%0d l=%0b",
                 cyc, out_valid, out_data, out_index, out_last, busy, h.data, cyc, cyc == 3);
      end
      void'(sb.pop_front());
      if (h.idx == 2'd3) exp_fc++;
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== exp_fc) begin
      failures++;
      $display("FAIL basic_end v=%0b busy=%0b fc=%0d want v=0 busy=0 fc=%0d",
               out_valid, busy, frame_count, exp_fc);
    end
  endtask

  task automatic test_stall();
    beat_t h;
    int cyc;
    out_ready = 1'b1;
    push_frame(32'd1, 32'd2, 32'd3, 32'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      h = sb[0];
      checks++;
      if (out_valid !== 1'b1 || out_data !== h.data || out_index !== h.idx ||
          out_last !== (h.idx == 2'd3)) begin
        failures++;
        $display("FAIL stall_beat cyc=%0d got v=%0b d=%0d i=%0d l=%0b want d=%0d i=%0d",
                 cyc, out_valid, out_data, out_index, out_last, h.data, h.idx);
      end
      if (out_ready) begin
        void'(sb.pop_front());
        if (h.idx == 2'd3) exp_fc++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== exp_fc) begin
      failures++;
      $display("FAIL stall_end left=%0d v=%0b busy=%0b fc=%0d want left=0 v=0 busy=0 fc=%0d",
               sb.size(), out_valid, busy, frame_count, exp_fc);
    end
  endtask

  task automatic test_back_to_back();
    beat_t h;
    int    cyc;
    bit    chained;
    out_ready = 1'b1;
    chained = 1'b0;
    push_frame(32'd1, 32'd2, 32'd3, 32'd4);
    start = 1'b1;
    step();
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      start = 1'b0;
      h = sb[0];
      checks++;
      if (out_valid !== 1'b1 || out_data !== h.data || out_index !== h.idx ||
          out_last !== (h.idx == 2'd3)) begin
        failures++;
        $display("FAIL b2b_beat cyc=%0d got v=%0b d=%0d i=%0d l=%0b want d=%0d i=%0d",
                 cyc, out_valid, out_data, out_index, out_last, h.data, h.idx);
      end
      void'(sb.pop_front());
      if (h.idx == 2'd3) begin
        exp_fc++;
        if (!chained) begin
          chained = 1'b1;
          push_frame(32'd5, 32'd6, 32'd7, 32'd8);
          start = 1'b1;
        end
      end
      step();
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc != 8 || out_valid !== 1'b0 || frame_count !== exp_fc) begin
      failures++;
      $display("FAIL b2b_end beats=%0d v=%0b fc=%0d want beats=8 v=0 fc=%0d",
               cyc, out_valid, frame_count, exp_fc);
    end
  endtask

  task automatic test_overrun();
    beat_t h;
    int    cyc;
    out_ready = 1'b1;
    push_frame(32'd1, 32'd2, 32'd3, 32'd4);
    start = 1'b1;
    step();
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      start = 1'b0;
      clr_overrun = 1'b0;
      h = sb[0];
      checks++;
      if (out_valid !== 1'b1 || out_data !== h.data || out_index !== h.idx) begin
        failures++;
        $display("FAIL ovr_beat cyc=%0d got v=%0b d=%0d i=%0d want d=%0d i=%0d",
                 cyc, out_valid, out_data, out_index, h.data, h.idx);
      end
      if (cyc >= 2) begin
        checks++;
        if (overrun !== 1'b1) begin
          failures++;
          $display("FAIL ovr_sticky cyc=%0d overrun=%0b want 1", cyc, overrun);
        end
      end
      if (cyc == 1 || cyc == 2) begin
        c11 = 32'd9; c12 = 32'd9; c21 = 32'd9; c22 = 32'd9;
        start = 1'b1;
        clr_overrun = (cyc == 2);
      end
      void'(sb.pop_front());
      if (h.idx == 2'd3) exp_fc++;
      step();
      cyc++;
    end
    start = 1'b0;
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b0 || frame_count !== exp_fc) begin
      failures++;
      $display("FAIL ovr_after ovr=%0b v=%0b fc=%0d want ovr=1 v=0 fc=%0d",
               overrun, out_valid, frame_count, exp_fc);
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear overrun=%0b want 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    beat_t h;
    int    cyc;
    out_ready = 1'b1;
    push_frame(32'd1, 32'd2, 32'd3, 32'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      void'(sb.pop_front());
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd2) begin
      failures++;
      $display("FAIL rstmid_pre v=%0b i=%0d want v=1 i=2", out_valid, out_index);
    end
    rst_n = 1'b0;
    start = 1'b1;
    step();
    rst_n = 1'b1;
    start = 1'b0;
    sb.delete();
    exp_fc = 8'd0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_post v=%0b busy=%0b fc=%0d want 0 0 0", out_valid, busy, frame_count);
    end
    push_frame(32'd10, 32'd20, 32'd30, 32'd40);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      h = sb[0];
      checks++;
      if (out_valid !== 1'b1 || out_data !== h.data || out_index !== h.idx) begin
        failures++;
        $display("FAIL rstmid_beat cyc=%0d got v=%0b d=%0d i=%0d want d=%0d i=%0d",
                 cyc, out_valid, out_data, out_index, h.data, h.idx);
      end
      void'(sb.pop_front());
      if (h.idx == 2'd3) exp_fc++;
      step();
      cyc++;
    end
    checks++;
    if (frame_count !== exp_fc || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_end fc=%0d v=%0b want fc=%0d v=0", frame_count, out_valid, exp_fc);
    end
  endtask

  task automatic test_wrap();
    beat_t h;
    int    cyc;
    int    started;
    int    n;
    int    bad;
    n = 256 - int'(exp_fc);
    started = 0;
    cyc = 0;
    bad = 0;
    while ((sb.size() > 0 || started < n) && cyc < 8000) begin
      start = 1'b0;
      c11 = $urandom; c12 = $urandom; c21 = $urandom; c22 = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      if (sb.size() == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          bad++;
          if (bad < 5) $display("FAIL wrap_idle cyc=%0d out_valid=%0b want 0", cyc, out_valid);
        end
        push_frame($urandom, $urandom, $urandom, $urandom);
        start = 1'b1;
        started++;
      end else begin
        h = sb[0];
        checks++;
        if (out_valid !== 1'b1 || out_data !== h.data || out_index !== h.idx ||
            out_last !== (h.idx == 2'd3)) begin
          failures++;
          bad++;
          if (bad < 5)
            $display("FAIL wrap_beat cyc=%0d got v=%0b d=%0h i=%0d want d=%0h i=%0d",
                     cyc, out_valid, out_data, out_index, h.data, h.idx);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          if (h.idx == 2'd3) begin
            exp_fc++;
            if (started < n) begin
              push_frame($urandom, $urandom, $urandom, $urandom);
              start = 1'b1;
              started++;
            end
          end
        end
      end
      step();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sb.size() != 0 || frame_count !== exp_fc || frame_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap_end left=%0d fc=%0d want left=0 fc=0", sb.size(), frame_count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_fc = 8'd0;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    clr_overrun = 1'b0;
    c11 = '0; c12 = '0; c21 = '0; c22 = '0;
    step();
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
